execute: RTL and testbench

//   EX stage of the 5-stage RV32 pipeline: sits between decode (id_exe regs) and mem_access.

---
 rtl/execute.sv | 206 ++++++++++++++++++++
 tb/tb_execute.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/execute.sv
// EX stage of the RV32 pipeline: operand-B select, ALU, BEQ resolution, and an
// iterative shift-add multiplier that stalls decode while it runs.
module execute #(
    parameter int unsigned MulCycles = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid_id_exe,
    input  logic        flush_exe,
    input  logic [3:0]  alu_op_id_exe,
    input  logic        alu_src_id_exe,
    input  logic [31:0] rs1_data_id_exe,
    input  logic [31:0] rs2_data_id_exe,
    input  logic [31:0] imm_id_exe,
    input  logic [31:0] pc_id_exe,
    input  logic [4:0]  write_reg_id_exe,
    input  logic        ctrl_branch_id_exe,
    input  logic        ctrl_mem_read_id_exe,
    input  logic        ctrl_mem_write_id_exe,
    input  logic        ctrl_mem_to_reg_id_exe,
    input  logic        ctrl_write_reg_id_exe,
    output logic        stall_exe,
    output logic [31:0] alu_out_exe_mem,
    output logic [31:0] w_data_exe_mem,
    output logic [4:0]  write_reg_exe_mem,
    output logic [31:0] branch_target_exe_mem,
    output logic        ctrl_branch_exe_mem,
    output logic        ctrl_mem_read_exe_mem,
    output logic        ctrl_mem_write_exe_mem,
    output logic        ctrl_mem_to_reg_exe_mem,
    output logic        ctrl_write_reg_exe_mem
);

    localparam int unsigned DataW = 32;
    localparam int unsigned CntW  = $clog2(MulCycles);
    localparam logic [3:0]  OpMul = 4'd10;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

    typedef struct packed {
        logic branch;
        logic mem_read;
        logic mem_write;
        logic mem_to_reg;
        logic write_reg;
    } ctrl_t;

    state_e             state_q, state_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [DataW-1:0]   acc_q, acc_d;
    logic [DataW-1:0]   mul_a_q, mul_a_d;
    logic [DataW-1:0]   mul_b_q, mul_b_d;
    ctrl_t              hold_ctrl_q, hold_ctrl_d;
    logic [4:0]         hold_wreg_q, hold_wreg_d;
    logic [DataW-1:0]   hold_wdata_q, hold_wdata_d;
    logic [DataW-1:0]   hold_target_q, hold_target_d;

    logic [DataW-1:0]   alu_out_q, alu_out_d;
    logic [DataW-1:0]   w_data_q, w_data_d;
    logic [4:0]         write_reg_q, write_reg_d;
    logic [DataW-1:0]   target_q, target_d;
    ctrl_t              ctrl_q, ctrl_d;

    logic [DataW-1:0]   op_b;
    logic [DataW-1:0]   alu_res;
    logic [4:0]         shamt;
    ctrl_t              in_ctrl;
    logic               is_mul;

    assign op_b   = alu_src_id_exe ? imm_id_exe : rs2_data_id_exe;
    assign shamt  = op_b[4:0];
    assign is_mul = valid_id_exe && (alu_op_id_exe == OpMul);

    // Branch is resolved here so the taken flag travels with the instruction.
    assign in_ctrl = '{branch:     ctrl_branch_id_exe && (rs1_data_id_exe == rs2_data_id_exe),
                       mem_read:   ctrl_mem_read_id_exe,
                       mem_write:  ctrl_mem_write_id_exe,
                       mem_to_reg: ctrl_mem_to_reg_id_exe,
                       write_reg:  ctrl_write_reg_id_exe};

    always_comb begin
        unique case (alu_op_id_exe)
            4'd1:    alu_res = rs1_data_id_exe - op_b;
            4'd2:    alu_res = rs1_data_id_exe << shamt;
            4'd3:    alu_res = {31'b0, $signed(rs1_data_id_exe) < $signed(op_b)};
            4'd4:    alu_res = {31'b0, rs1_data_id_exe < op_b};
            4'd5:    alu_res = rs1_data_id_exe ^ op_b;
            4'd6:    alu_res = rs1_data_id_exe >> shamt;
            4'd7:    alu_res = DataW'($signed(rs1_data_id_exe) >>> shamt);
            4'd8:    alu_res = rs1_data_id_exe | op_b;
            4'd9:    alu_res = rs1_data_id_exe & op_b;
            4'd11:   alu_res = op_b;
            default: alu_res = rs1_data_id_exe + op_b;
        endcase
    end

    // Stall drops in the flush cycle so decode can refill immediately.
    assign stall_exe = rst_n && !flush_exe &&
                       ((state_q == IDLE && is_mul) || state_q == BUSY);

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        acc_d         = acc_q;
        mul_a_d       = mul_a_q;
        mul_b_d       = mul_b_q;
        hold_ctrl_d   = hold_ctrl_q;
        hold_wreg_d   = hold_wreg_q;
        hold_wdata_d  = hold_wdata_q;
        hold_target_d = hold_target_q;
        alu_out_d     = alu_out_q;
        w_data_d      = w_data_q;
        write_reg_d   = write_reg_q;
        target_d      = target_q;
        ctrl_d        = '0;

        if (flush_exe) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (is_mul) begin
                        state_d       = BUSY;
                        cnt_d         = '0;
                        acc_d         = '0;
                        mul_a_d       = rs1_data_id_exe;
                        mul_b_d       = op_b;
                        hold_ctrl_d   = in_ctrl;
                        hold_wreg_d   = write_reg_id_exe;
                        hold_wdata_d  = rs2_data_id_exe;
                        hold_target_d = pc_id_exe + imm_id_exe;
                    end else if (valid_id_exe) begin
                        alu_out_d   = alu_res;
                        w_data_d    = rs2_data_id_exe;
                        write_reg_d = write_reg_id_exe;
                        target_d    = pc_id_exe + imm_id_exe;
                        ctrl_d      = in_ctrl;
                    end
                end
                BUSY: begin
                    acc_d = acc_q + (mul_b_q[cnt_q] ? (mul_a_q << cnt_q) : '0);
                    cnt_d = cnt_q + CntW'(1);
                    if (cnt_q == CntW'(MulCycles - 1)) begin
                        state_d = DONE;
                    end
                end
                DONE: begin
                    state_d     = IDLE;
                    cnt_d       = '0;
                    alu_out_d   = acc_q;
                    w_data_d    = hold_wdata_q;
                    write_reg_d = hold_wreg_q;
                    target_d    = hold_target_q;
                    ctrl_d      = hold_ctrl_q;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            acc_q         <= '0;
            mul_a_q       <= '0;
            mul_b_q       <= '0;
            hold_ctrl_q   <= '0;
            hold_wreg_q   <= '0;
            hold_wdata_q  <= '0;
            hold_target_q <= '0;
            alu_out_q     <= '0;
            w_data_q      <= '0;
            write_reg_q   <= '0;
            target_q      <= '0;
            ctrl_q        <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            acc_q         <= acc_d;
            mul_a_q       <= mul_a_d;
            mul_b_q       <= mul_b_d;
            hold_ctrl_q   <= hold_ctrl_d;
            hold_wreg_q   <= hold_wreg_d;
            hold_wdata_q  <= hold_wdata_d;
            hold_target_q <= hold_target_d;
            alu_out_q     <= alu_out_d;
            w_data_q      <= w_data_d;
            write_reg_q   <= write_reg_d;
            target_q      <= target_d;
            ctrl_q        <= ctrl_d;
        end
    end

    assign alu_out_exe_mem         = alu_out_q;
    assign w_data_exe_mem          = w_data_q;
    assign write_reg_exe_mem       = write_reg_q;
    assign branch_target_exe_mem   = target_q;
    assign ctrl_branch_exe_mem     = ctrl_q.branch;
    assign ctrl_mem_read_exe_mem   = ctrl_q.mem_read;
    assign ctrl_mem_write_exe_mem  = ctrl_q.mem_write;
    assign ctrl_mem_to_reg_exe_mem = ctrl_q.mem_to_reg;
    assign ctrl_write_reg_exe_mem  = ctrl_q.write_reg;

endmodule

// File: tb/tb_execute.sv
// Self-checking bench for execute: a transaction-level model checked every cycle,
// plus directed vectors with hand-computed results.
module tb_execute;

    localparam int MulCycles = 32;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_id_exe = 1'b0;
    logic        flush_exe = 1'b0;
    logic [3:0]  alu_op_id_exe = '0;
    logic        alu_src_id_exe = 1'b0;
    logic [31:0] rs1_data_id_exe = '0;
    logic [31:0] rs2_data_id_exe = '0;
    logic [31:0] imm_id_exe = '0;
    logic [31:0] pc_id_exe = '0;
    logic [4:0]  write_reg_id_exe = '0;
    logic        ctrl_branch_id_exe = 1'b0;
    logic        ctrl_mem_read_id_exe = 1'b0;
    logic        ctrl_mem_write_id_exe = 1'b0;
    logic        ctrl_mem_to_reg_id_exe = 1'b0;
    logic        ctrl_write_reg_id_exe = 1'b0;
    logic        stall_exe;
    logic [31:0] alu_out_exe_mem;
    logic [31:0] w_data_exe_mem;
    logic [4:0]  write_reg_exe_mem;
    logic [31:0] branch_target_exe_mem;
    logic        ctrl_branch_exe_mem;
    logic        ctrl_mem_read_exe_mem;
    logic        ctrl_mem_write_exe_mem;
    logic        ctrl_mem_to_reg_exe_mem;
    logic        ctrl_write_reg_exe_mem;

    int checks = 0;
    int errors = 0;

    execute #(.MulCycles(MulCycles)) dut (
        .clk(clk), .rst_n(rst_n),
        .valid_id_exe(valid_id_exe), .flush_exe(flush_exe),
        .alu_op_id_exe(alu_op_id_exe), .alu_src_id_exe(alu_src_id_exe),
        .rs1_data_id_exe(rs1_data_id_exe), .rs2_data_id_exe(rs2_data_id_exe),
        .imm_id_exe(imm_id_exe), .pc_id_exe(pc_id_exe),
        .write_reg_id_exe(write_reg_id_exe),
        .ctrl_branch_id_exe(ctrl_branch_id_exe),
        .ctrl_mem_read_id_exe(ctrl_mem_read_id_exe),
        .ctrl_mem_write_id_exe(ctrl_mem_write_id_exe),
        .ctrl_mem_to_reg_id_exe(ctrl_mem_to_reg_id_exe),
        .ctrl_write_reg_id_exe(ctrl_write_reg_id_exe),
        .stall_exe(stall_exe),
        .alu_out_exe_mem(alu_out_exe_mem), .w_data_exe_mem(w_data_exe_mem),
        .write_reg_exe_mem(write_reg_exe_mem),
        .branch_target_exe_mem(branch_target_exe_mem),
        .ctrl_branch_exe_mem(ctrl_branch_exe_mem),
        .ctrl_mem_read_exe_mem(ctrl_mem_read_exe_mem),
        .ctrl_mem_write_exe_mem(ctrl_mem_write_exe_mem),
        .ctrl_mem_to_reg_exe_mem(ctrl_mem_to_reg_exe_mem),
        .ctrl_write_reg_exe_mem(ctrl_write_reg_exe_mem)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Architectural ALU result from the instruction-set definition.
    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        int sh;
        sh = int'(b % 32);
        case (op)
            4'd1:    return a - b;
            4'd2:    return a << sh;
            4'd3:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd4:    return (a < b) ? 32'd1 : 32'd0;
            4'd5:    return a ^ b;
            4'd6:    return a >> sh;
            4'd7:    return 32'($signed(a) >>> sh);
            4'd8:    return a | b;
            4'd9:    return a & b;
            4'd11:   return b;
            default: return a + b;
        endcase
    endfunction

    // Model: a MUL occupies the stage for MulCycles+1 edges after acceptance.
    int          mul_left = 0;
    logic [31:0] h_res = '0, h_wdata = '0, h_tgt = '0;
    logic [4:0]  h_wreg = '0, h_ctrl = '0;
    logic        exp_emit = 1'b0;
    logic [4:0]  exp_ctrl = '0;
    logic [31:0] exp_alu = '0, exp_wdata = '0, exp_tgt = '0;
    logic [4:0]  exp_wreg = '0;

    function automatic logic [4:0] in_ctrl();
        return {ctrl_branch_id_exe && (rs1_data_id_exe == rs2_data_id_exe),
                ctrl_mem_read_id_exe, ctrl_mem_write_id_exe,
                ctrl_mem_to_reg_id_exe, ctrl_write_reg_id_exe};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mul_left <= 0;
            exp_emit <= 1'b0;
            exp_ctrl <= '0;
        end else begin
            exp_emit <= 1'b0;
            exp_ctrl <= '0;
            if (flush_exe) begin
                mul_left <= 0;
            end else if (mul_left > 1) begin
                mul_left <= mul_left - 1;
            end else if (mul_left == 1) begin
                mul_left  <= 0;
                exp_emit  <= 1'b1;
                exp_ctrl  <= h_ctrl;
                exp_alu   <= h_res;
                exp_wdata <= h_wdata;
                exp_wreg  <= h_wreg;
                exp_tgt   <= h_tgt;
            end else if (valid_id_exe) begin
                if (alu_op_id_exe == 4'd10) begin
                    mul_left <= MulCycles + 1;
                    h_res    <= rs1_data_id_exe *
                                (alu_src_id_exe ? imm_id_exe : rs2_data_id_exe);
                    h_ctrl   <= in_ctrl();
                    h_wdata  <= rs2_data_id_exe;
                    h_wreg   <= write_reg_id_exe;
                    h_tgt    <= pc_id_exe + imm_id_exe;
                end else begin
                    exp_emit  <= 1'b1;
                    exp_ctrl  <= in_ctrl();
                    exp_alu   <= ref_alu(alu_op_id_exe, rs1_data_id_exe,
                                         alu_src_id_exe ? imm_id_exe : rs2_data_id_exe);
                    exp_wdata <= rs2_data_id_exe;
                    exp_wreg  <= write_reg_id_exe;
                    exp_tgt   <= pc_id_exe + imm_id_exe;
                end
            end
        end
    end

    // Compare process: every cycle on the falling edge.
    always @(negedge clk) begin
        logic exp_stall;
        exp_stall = rst_n && !flush_exe &&
                    ((mul_left > 1) ||
                     (mul_left == 0 && valid_id_exe && alu_op_id_exe == 4'd10));
        chk("stall", {31'b0, stall_exe}, {31'b0, exp_stall});
        chk("ctrl", {27'b0, ctrl_branch_exe_mem, ctrl_mem_read_exe_mem,
                     ctrl_mem_write_exe_mem, ctrl_mem_to_reg_exe_mem,
                     ctrl_write_reg_exe_mem}, {27'b0, exp_ctrl});
        if (exp_emit) begin
            chk("alu_out", alu_out_exe_mem, exp_alu);
            chk("w_data", w_data_exe_mem, exp_wdata);
            chk("write_reg", {27'b0, write_reg_exe_mem}, {27'b0, exp_wreg});
            chk("target", branch_target_exe_mem, exp_tgt);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ctl = {branch, mem_read, mem_write, mem_to_reg, write_reg}
    task automatic drive(input logic [3:0] op, input logic src, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] imm, input logic [31:0] pc,
                         input logic [4:0] wr, input logic [4:0] ctl);
        valid_id_exe           = 1'b1;
        alu_op_id_exe          = op;
        alu_src_id_exe         = src;
        rs1_data_id_exe        = a;
        rs2_data_id_exe        = b;
        imm_id_exe             = imm;
        pc_id_exe              = pc;
        write_reg_id_exe       = wr;
        {ctrl_branch_id_exe, ctrl_mem_read_id_exe, ctrl_mem_write_id_exe,
         ctrl_mem_to_reg_id_exe, ctrl_write_reg_id_exe} = ctl;
    endtask

    // Present an instruction and hold it, as decode would, until the stage accepts it.
    task automatic issue(input logic [3:0] op, input logic src, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] imm, input logic [31:0] pc,
                         input logic [4:0] wr, input logic [4:0] ctl, output int stalls);
        logic s;
        drive(op, src, a, b, imm, pc, wr, ctl);
        stalls = 0;
        forever begin
            @(negedge clk);
            s = stall_exe;
            step();
            if (!s) break;
            stalls++;
            if (stalls > 100) begin
                errors++;
                $display("FAIL issue_timeout: stall still high after %0d cycles, expected release", stalls);
                break;
            end
        end
    endtask

    task automatic bubble(input int n);
        valid_id_exe = 1'b0;
        repeat (n) step();
    endtask

    initial begin
        int st;
        logic [3:0]  t_op  [8] = '{4'd1, 4'd2, 4'd5, 4'd6, 4'd8, 4'd9, 4'd11, 4'd13};
        logic [31:0] t_a   [8] = '{32'd10, 32'h0000_0001, 32'hF0F0_1234, 32'h8000_0010,
                                   32'h1200_0034, 32'hFFFF_00FF, 32'h0, 32'h7FFF_FFFF};
        logic [31:0] t_b   [8] = '{32'd3, 32'h0000_0021, 32'h0FF0_4321, 32'h0000_0024,
                                   32'h0056_7800, 32'h0F0F_0F0F, 32'hDEAD_BEEF, 32'h1};
        logic [4:0]  t_ctl [8] = '{5'b00001, 5'b00001, 5'b00100, 5'b01011, 5'b00001,
                                   5'b00000, 5'b00001, 5'b10001};

        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) step();
        chk("reset_alu_out", alu_out_exe_mem, 32'h0);
        chk("reset_ctrl_wr", {31'b0, ctrl_write_reg_exe_mem}, 32'h0);
        chk("reset_stall", {31'b0, stall_exe}, 32'h0);
        rst_n = 1'b1;
        step();

        issue(4'd0, 1'b0, 32'd5, 32'd7, 32'd0, 32'd0, 5'd3, 5'b00001, st);
        chk("add_result", alu_out_exe_mem, 32'd12);
        chk("add_wreg", {27'b0, write_reg_exe_mem}, 32'd3);
        chk("add_ctrl_wr", {31'b0, ctrl_write_reg_exe_mem}, 32'd1);

        issue(4'd7, 1'b1, 32'h8000_0000, 32'd0, 32'd4, 32'd0, 5'd4, 5'b00001, st);
        chk("sra_result", alu_out_exe_mem, 32'hF800_0000);
        issue(4'd4, 1'b0, 32'd1, 32'hFFFF_FFFF, 32'd0, 32'd0, 5'd5, 5'b00001, st);
        chk("sltu_result", alu_out_exe_mem, 32'd1);
        issue(4'd3, 1'b0, 32'd1, 32'hFFFF_FFFF, 32'd0, 32'd0, 5'd6, 5'b00001, st);
        chk("slt_result", alu_out_exe_mem, 32'd0);

        for (int i = 0; i < 8; i++)
            issue(t_op[i], i == 6, t_a[i], t_b[i], t_b[i] ^ 32'h55, 32'h40 + 32'(i * 4),
                  5'(i + 8), t_ctl[i], st);
        bubble(2);

        issue(4'd10, 1'b0, 32'h1234_5678, 32'h9ABC_DEF0, 32'd0, 32'h200, 5'd7, 5'b00001, st);
        chk("mul_stall_cycles", 32'(st), 32'd33);
        chk("mul_result", alu_out_exe_mem, 32'h242D_2080);
        chk("mul_ctrl_wr", {31'b0, ctrl_write_reg_exe_mem}, 32'd1);
        issue(4'd10, 1'b1, 32'hFFFF_FFFD, 32'd0, 32'd7, 32'h0, 5'd9, 5'b00001, st);
        bubble(2);

        issue(4'd0, 1'b0, 32'd9, 32'd9, 32'h20, 32'h100, 5'd0, 5'b10000, st);
        chk("beq_taken", {31'b0, ctrl_branch_exe_mem}, 32'd1);
        chk("beq_target", branch_target_exe_mem, 32'h120);
        issue(4'd0, 1'b0, 32'd9, 32'd8, 32'h20, 32'h100, 5'd0, 5'b10000, st);
        chk("beq_not_taken", {31'b0, ctrl_branch_exe_mem}, 32'd0);
        bubble(2);

        // MUL aborted by flush in its tenth busy cycle.
        drive(4'd10, 1'b0, 32'd3, 32'd5, 32'd0, 32'd0, 5'd10, 5'b00001);
        repeat (10) step();
        flush_exe = 1'b1;
        #1;
        chk("flush_stall_drop", {31'b0, stall_exe}, 32'd0);
        step();
        flush_exe = 1'b0;
        chk("flush_no_result", {31'b0, ctrl_write_reg_exe_mem}, 32'd0);
        issue(4'd0, 1'b0, 32'd1, 32'd2, 32'd0, 32'd0, 5'd11, 5'b00001, st);
        chk("after_flush_add", alu_out_exe_mem, 32'd3);

        // MUL arriving together with flush is never started.
        drive(4'd10, 1'b0, 32'd3, 32'd5, 32'd0, 32'd0, 5'd12, 5'b00001);
        flush_exe = 1'b1;
        #1;
        chk("flush_mul_nostart", {31'b0, stall_exe}, 32'd0);
        step();
        flush_exe = 1'b0;
        bubble(3);

        // Reset in the middle of a MUL.
        drive(4'd10, 1'b0, 32'd6, 32'd7, 32'd0, 32'd0, 5'd13, 5'b00001);
        repeat (5) step();
        #2;
        rst_n = 1'b0;
        valid_id_exe = 1'b0;
        #1;
        chk("rst_mid_alu_out", alu_out_exe_mem, 32'h0);
        chk("rst_mid_wreg", {27'b0, write_reg_exe_mem}, 32'h0);
        chk("rst_mid_stall", {31'b0, stall_exe}, 32'h0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        step();
        chk("rst_release_stall", {31'b0, stall_exe}, 32'h0);
        issue(4'd0, 1'b0, 32'd20, 32'd22, 32'd0, 32'd0, 5'd14, 5'b00001, st);
        chk("after_rst_add", alu_out_exe_mem, 32'd42);
        bubble(40);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
